tcdm_rr_arbiter: RTL and testbench
==================================

Name: tcdm_rr_arbiter

Overview:
- Round-robin arbiter that shares one TCDM memory port between NR requesters, such as streamer source/sink ports or a testbench DMA.
- Sits between the requesters and a single-port TCDM slave: the testbench memory model or a bank.
- Muxes request, address, data and byte enables to the slave, returns grants to the winning requester and routes the response back to the requester that issued it.
- The slave has a fixed 1-cycle response latency: r_valid is asserted the cycle after an accepted request, for both reads and writes.

Parameters:
- NR, 4, number of requesters (2..16)
- AW, 32, address width
- DW, 32, data width
- BW, DW/8, byte-enable width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear of the arbitration state
- req_i  in  NR  per-requester request
- add_i  in  NR*AW  per-requester address; slice i = [i*AW +: AW]
- wen_i  in  NR  per-requester write-enable-n: 1 = read, 0 = write
- be_i  in  NR*BW  per-requester byte enables
- data_i  in  NR*DW  per-requester write data
- gnt_o  out  NR  per-requester grant (combinational)
- r_data_o  out  DW  response data, broadcast to all requesters
- r_valid_o  out  NR  per-requester response valid, one-hot or zero
- mem_req_o  out  1  request to slave
- mem_add_o  out  AW  address to slave
- mem_wen_o  out  1  wen to slave
- mem_be_o  out  BW  byte enables to slave
- mem_data_o  out  DW  write data to slave
- mem_gnt_i  in  1  slave grant
- mem_r_data_i  in  DW  slave response data
- mem_r_valid_i  in  1  slave response valid
- err_o  out  1  sticky error: response received with nothing pending
- txn_cnt_o  out  32  count of accepted transactions, wraps at 2^32

Behaviour:
- State: rr_ptr_q (clog2(NR) bits), pend_q (1), pend_idx_q (clog2(NR)), err_q, txn_cnt_q. All reset to 0 on rst_ni low, asynchronously.
- Winner selection (combinational): first i with req_i[i]=1, scanning rr_ptr_q, rr_ptr_q+1, ... modulo NR.
- mem_req_o = |req_i. The mem_add_o/wen/be/data outputs carry the winner's fields. When no request is present they drive 0 and mem_wen_o drives 1.
- gnt_o[w] = mem_gnt_i for the winner w. All other gnt_o bits are 0. There is no combinational path from mem_gnt_i into winner selection.
- Accepted transaction: the cycle where mem_req_o & mem_gnt_i. On that edge:
  - rr_ptr_q <= (w+1) mod NR
  - pend_q <= 1
  - pend_idx_q <= w
  - txn_cnt_q += 1
- Cycle with no accept: pend_q <= 0. rr_ptr_q is held, including when mem_gnt_i=0 with requests pending; the same winner is retried.
- Back-to-back accepts are allowed every cycle. pend_q/pend_idx_q are overwritten each cycle, which is valid because latency is exactly 1.
- Response: r_valid_o[pend_idx_q] = mem_r_valid_i & pend_q. All other r_valid_o bits are 0. r_data_o = mem_r_data_i unconditionally.
- mem_r_valid_i=1 with pend_q=0: the response is dropped, r_valid_o stays 0, and err_q <= 1. err_q is cleared only by reset or clear_i.
- A write's loopback response is routed exactly like a read's.
- clear_i (sync):
  - Clears rr_ptr_q, err_q and txn_cnt_q.
  - pend_q/pend_idx_q are NOT cleared, so an in-flight response still returns to its owner.
  - An accept in the same cycle still sets pend_q/pend_idx_q.
  - clear_i wins over the rr_ptr_q and txn_cnt_q updates.
- Reset mid-operation: pending response state is lost. Any slave response arriving after reset deassert is dropped and sets err_o.
- Fairness: under continuous requests from all NR requesters with mem_gnt_i=1, each requester is granted exactly once per NR cycles.
- NR=1 is not supported; elaboration-time assertion.

Test Plan:
- Single requester: req_i=4'b0100, read at 0x10, mem_gnt_i=1 → gnt_o=4'b0100 same cycle; next cycle r_valid_o=4'b0100 with memory data; txn_cnt_o=1.
- All four requesting continuously for 8 cycles, mem_gnt_i=1 → grant order 0,1,2,3,0,1,2,3; each r_valid_o matches the grant one cycle earlier; txn_cnt_o=8.
- Backpressure: req_i=4'b0011, rr_ptr=0, mem_gnt_i=0 for 3 cycles then 1 → gnt_o=0 for 3 cycles, then 4'b0001; rr_ptr_q becomes 1 and the next grant goes to 1.
- Write then read from different requesters: req0 writes 0xDEADBEEF with be=4'b0011 to 0x20, then req1 reads 0x20 → req1 gets 0x0000BEEF (memory initialised to 0), and only req1's r_valid_o fires.
- Spurious mem_r_valid_i with no prior accept → r_valid_o=0, err_o=1 until clear_i; clear_i also zeroes txn_cnt_o and rr_ptr.
- Reset asserted in the cycle after an accept → all outputs 0 asynchronously; the late response is dropped and err_o=1 after release.

Source files
------------

// File: rtl/tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_rr_arbiter
// Description : Round-robin arbiter sharing one single-port TCDM slave
//               (fixed 1-cycle response latency) between NR requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_rr_arbiter #(
    parameter int NR = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = DW / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [NR-1:0]    req_i,
    input  logic [NR*AW-1:0] add_i,
    input  logic [NR-1:0]    wen_i,
    input  logic [NR*BW-1:0] be_i,
    input  logic [NR*DW-1:0] data_i,
    output logic [NR-1:0]    gnt_o,
    output logic [DW-1:0]    r_data_o,
    output logic [NR-1:0]    r_valid_o,
    output logic             mem_req_o,
    output logic [AW-1:0]    mem_add_o,
    output logic             mem_wen_o,
    output logic [BW-1:0]    mem_be_o,
    output logic [DW-1:0]    mem_data_o,
    input  logic             mem_gnt_i,
    input  logic [DW-1:0]    mem_r_data_i,
    input  logic             mem_r_valid_i,
    output logic             err_o,
    output logic [31:0]      txn_cnt_o
);

    localparam int c_IW = (NR > 1) ? $clog2(NR) : 1;
    localparam int c_SW = c_IW + 1;

    if (NR < 2) begin : g_nr_check
        $error("tcdm_rr_arbiter: NR must be at least 2");
    end

    logic [c_IW-1:0] r_rr_ptr;
    logic            r_pend;
    logic [c_IW-1:0] r_pend_idx;
    logic            r_err;
    logic [31:0]     r_txn_cnt;

    logic [c_IW-1:0] w_win;
    logic [c_IW-1:0] w_ptr_nxt;
    logic            w_accept;

    // Scan from the highest offset down so the first requester after the
    // pointer is the last one written, i.e. the winner.
    always_comb begin
        logic [c_SW-1:0] w_sum;
        w_win = '0;
        w_sum = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + c_SW'(k);
            if (w_sum >= c_SW'(NR)) begin
                w_sum = w_sum - c_SW'(NR);
            end
            if (req_i[w_sum[c_IW-1:0]]) begin
                w_win = w_sum[c_IW-1:0];
            end
        end
    end

    assign mem_req_o = |req_i;
    assign w_accept  = mem_req_o & mem_gnt_i;
    assign w_ptr_nxt = (w_win == c_IW'(NR - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        gnt_o      = '0;
        mem_add_o  = '0;
        mem_wen_o  = 1'b1;
        mem_be_o   = '0;
        mem_data_o = '0;
        for (int i = 0; i < NR; i++) begin
            if (mem_req_o && (w_win == c_IW'(i))) begin
                gnt_o[i]   = mem_gnt_i;
                mem_add_o  = add_i[i*AW +: AW];
                mem_wen_o  = wen_i[i];
                mem_be_o   = be_i[i*BW +: BW];
                mem_data_o = data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        for (int i = 0; i < NR; i++) begin
            r_valid_o[i] = mem_r_valid_i & r_pend & (r_pend_idx == c_IW'(i));
        end
    end

    assign r_data_o  = mem_r_data_i;
    assign err_o     = r_err;
    assign txn_cnt_o = r_txn_cnt;

    // Pending owner is kept across clear_i so an in-flight response still
    // finds its requester; latency is exactly one cycle, so one slot suffices.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_err      <= 1'b0;
            r_txn_cnt  <= '0;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_pend_idx <= w_win;
            end
            if (clear_i) begin
                r_rr_ptr  <= '0;
                r_err     <= 1'b0;
                r_txn_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_rr_ptr  <= w_ptr_nxt;
                    r_txn_cnt <= r_txn_cnt + 32'd1;
                end
                if (mem_r_valid_i && !r_pend) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_rr_arbiter
// Description : Directed scoreboard bench for tcdm_rr_arbiter with a
//               1-cycle-latency memory slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic [NR-1:0]    req_i;
    logic [NR*AW-1:0] add_i;
    logic [NR-1:0]    wen_i;
    logic [NR*BW-1:0] be_i;
    logic [NR*DW-1:0] data_i;
    logic [NR-1:0]    gnt_o;
    logic [DW-1:0]    r_data_o;
    logic [NR-1:0]    r_valid_o;
    logic             mem_req_o;
    logic [AW-1:0]    mem_add_o;
    logic             mem_wen_o;
    logic [BW-1:0]    mem_be_o;
    logic [DW-1:0]    mem_data_o;
    logic             mem_gnt_i;
    logic [DW-1:0]    mem_r_data_i = '0;
    logic             mem_r_valid_i = 1'b0;
    logic             err_o;
    logic [31:0]      txn_cnt_o;

    tcdm_rr_arbiter #(.NR(NR), .AW(AW), .DW(DW), .BW(BW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_i         (req_i),
        .add_i         (add_i),
        .wen_i         (wen_i),
        .be_i          (be_i),
        .data_i        (data_i),
        .gnt_o         (gnt_o),
        .r_data_o      (r_data_o),
        .r_valid_o     (r_valid_o),
        .mem_req_o     (mem_req_o),
        .mem_add_o     (mem_add_o),
        .mem_wen_o     (mem_wen_o),
        .mem_be_o      (mem_be_o),
        .mem_data_o    (mem_data_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_r_data_i  (mem_r_data_i),
        .mem_r_valid_i (mem_r_valid_i),
        .err_o         (err_o),
        .txn_cnt_o     (txn_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    // Slave: responds one cycle after every accepted request; spurious
    // injects a response with no request behind it.
    logic [DW-1:0] slv_mem [64] = '{default: '0};
    logic          spurious = 1'b0;

    always @(posedge clk_i) begin
        mem_r_valid_i <= (mem_req_o && mem_gnt_i) || spurious;
        if (mem_req_o && mem_gnt_i) begin
            if (mem_wen_o) begin
                mem_r_data_i <= slv_mem[mem_add_o[7:2]];
            end else begin
                slv_mem[mem_add_o[7:2]] <= merge(slv_mem[mem_add_o[7:2]], mem_data_o, mem_be_o);
                mem_r_data_i <= '0;
            end
        end
    end

    typedef struct {
        int            idx;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [64];
    logic [AW-1:0] a_add [NR];
    logic          a_wen [NR];
    logic [BW-1:0] a_be  [NR];
    logic [DW-1:0] a_dat [NR];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            add_i[i*AW +: AW]  = a_add[i];
            wen_i[i]           = a_wen[i];
            be_i[i*BW +: BW]   = a_be[i];
            data_i[i*DW +: DW] = a_dat[i];
        end
    endtask

    // One clock cycle with inputs already applied; exp_w is the expected
    // winner (-1 when no request). Checks last cycle's response first.
    task automatic cyc(input int exp_w);
        exp_t e;
        apply();
        @(negedge clk_i);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("r_valid", 64'(r_valid_o), 64'(oh(e.idx)));
            if (e.rd) chk("r_data", 64'(r_data_o), 64'(e.data));
        end else begin
            chk("r_valid_idle", 64'(r_valid_o), 64'(0));
        end
        chk("gnt", 64'(gnt_o), 64'(mem_gnt_i ? oh(exp_w) : '0));
        chk("mem_req", 64'(mem_req_o), 64'(exp_w >= 0));
        if (exp_w >= 0) begin
            chk("mem_add", 64'(mem_add_o), 64'(a_add[exp_w]));
            if (mem_gnt_i) begin
                e.idx  = exp_w;
                e.rd   = a_wen[exp_w];
                e.data = ref_mem[a_add[exp_w][7:2]];
                sb.push_back(e);
                if (!a_wen[exp_w])
                    ref_mem[a_add[exp_w][7:2]] = merge(ref_mem[a_add[exp_w][7:2]],
                                                       a_dat[exp_w], a_be[exp_w]);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < NR; i++) begin
            a_add[i] = AW'(32'h40 + 4 * i);
            a_wen[i] = 1'b1;
            a_be[i]  = '1;
            a_dat[i] = '0;
        end
        rst_ni    = 1'b0;
        clear_i   = 1'b0;
        req_i     = '0;
        mem_gnt_i = 1'b1;
        apply();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_txn", 64'(txn_cnt_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_rvalid", 64'(r_valid_o), 64'(0));
        chk("rst_wen_idle", 64'(mem_wen_o), 64'(1));
        chk("rst_add_idle", 64'(mem_add_o), 64'(0));
        rst_ni = 1'b1;

        // Single requester read
        a_add[2] = 32'h10;
        req_i = 4'b0100;
        cyc(2);
        req_i = '0;
        cyc(-1);
        chk("single_txn", 64'(txn_cnt_o), 64'(1));

        // Fairness from a cleared pointer
        clear_i = 1'b1;
        cyc(-1);
        clear_i = 1'b0;
        req_i = 4'b1111;
        for (int k = 0; k < 8; k++) cyc(k % NR);
        req_i = '0;
        cyc(-1);
        chk("fair_txn", 64'(txn_cnt_o), 64'(8));

        // Backpressure holds the pointer on the same winner
        req_i = 4'b0011;
        mem_gnt_i = 1'b0;
        repeat (3) cyc(0);
        mem_gnt_i = 1'b1;
        cyc(0);
        cyc(1);
        req_i = '0;
        cyc(-1);
        chk("bp_txn", 64'(txn_cnt_o), 64'(10));

        // Partial write by requester 0, read back by requester 1
        a_add[0] = 32'h20; a_wen[0] = 1'b0; a_be[0] = 4'b0011; a_dat[0] = 32'hDEADBEEF;
        req_i = 4'b0001;
        cyc(0);
        a_add[1] = 32'h20;
        req_i = 4'b0010;
        cyc(1);
        req_i = '0;
        cyc(-1);
        chk("wr_rd_data", 64'(r_data_o), 64'(32'h0000BEEF));

        // Spurious response sets the sticky error
        spurious = 1'b1;
        @(posedge clk_i);
        #1;
        spurious = 1'b0;
        @(negedge clk_i);
        chk("spur_rvalid", 64'(r_valid_o), 64'(0));
        @(posedge clk_i);
        #1;
        chk("spur_err", 64'(err_o), 64'(1));
        cyc(-1);
        chk("err_sticky", 64'(err_o), 64'(1));
        clear_i = 1'b1;
        cyc(-1);
        clear_i = 1'b0;
        chk("clr_err", 64'(err_o), 64'(0));
        chk("clr_txn", 64'(txn_cnt_o), 64'(0));
        req_i = 4'b1111;
        cyc(0);
        req_i = '0;
        cyc(-1);

        // Clear coinciding with an accept keeps the pending owner
        clear_i = 1'b1;
        req_i = 4'b0010;
        cyc(1);
        req_i = '0;
        cyc(-1);
        clear_i = 1'b0;
        chk("clr_acc_txn", 64'(txn_cnt_o), 64'(0));
        req_i = 4'b0110;
        cyc(1);
        req_i = '0;
        cyc(-1);

        // Reset in the cycle after an accept drops the late response
        req_i = 4'b0100;
        apply();
        @(negedge clk_i);
        chk("pre_rst_gnt", 64'(gnt_o), 64'(4'b0100));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        req_i = '0;
        #1;
        chk("arst_txn", 64'(txn_cnt_o), 64'(0));
        chk("arst_rvalid", 64'(r_valid_o), 64'(0));
        chk("arst_gnt", 64'(gnt_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("late_err", 64'(err_o), 64'(1));
        chk("late_rvalid", 64'(r_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
